// File: rtl/scratch_ring_window_ctrl_pkg.sv
// Shared definitions for the scratchpad ring window controller: FSM encoding and
// the extra occupancy bit needed to represent a completely full ring.
package scratch_ring_window_ctrl_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_READ = 2'd2;
  localparam logic [1:0] ST_ADV  = 2'd3;

  // occupancy/win_len/stride width is ADDR_LEN + OCC_EXTRA_BITS (0..SCRATCH_DEPTH inclusive)
  localparam int OCC_EXTRA_BITS = 1;

endpackage

// File: rtl/scratch_ring_window_ctrl_ring_ptr_add.sv
// Combinational modular add for ring pointers of any depth: (a + b) mod SCRATCH_DEPTH,
// valid for a < SCRATCH_DEPTH and b <= SCRATCH_DEPTH.
module ring_ptr_add
  import scratch_ring_window_ctrl_pkg::*;
#(
  parameter int ADDR_LEN      = 4,
  parameter int SCRATCH_DEPTH = 16
) (
  input  logic [ADDR_LEN-1:0] a,
  input  logic [ADDR_LEN:0]   b,
  output logic [ADDR_LEN-1:0] sum
);

  localparam int              SUM_W = ADDR_LEN + OCC_EXTRA_BITS;
  localparam logic [SUM_W-1:0] DEPTH = SUM_W'(SCRATCH_DEPTH);

  logic [SUM_W-1:0] raw;

  // a + b < 2*DEPTH, so a single conditional subtract is enough
  always_comb begin
    raw = {1'b0, a} + b;
    sum = (raw >= DEPTH) ? ADDR_LEN'(raw - DEPTH) : ADDR_LEN'(raw);
  end

endmodule

// File: rtl/scratch_ring_window_ctrl.sv
// Circular scratchpad address controller: producer write pointer, sliding read window
// with configurable length/stride, and occupancy tracking for a ring of any depth.
module scratch_ring_window_ctrl
  import scratch_ring_window_ctrl_pkg::*;
#(
  parameter int ADDR_LEN      = 4,
  parameter int SCRATCH_DEPTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  output logic                wr_ready,
  output logic [ADDR_LEN-1:0] wr_addr,
  input  logic                start,
  input  logic [ADDR_LEN:0]   win_len,
  input  logic [ADDR_LEN:0]   stride,
  input  logic                rd_ready,
  output logic                rd_valid,
  output logic [ADDR_LEN-1:0] rd_addr,
  output logic                rd_last,
  output logic                done,
  output logic                err,
  output logic                busy,
  output logic [ADDR_LEN:0]   occupancy,
  output logic                full,
  output logic                empty
);

  localparam int               OCC_W = ADDR_LEN + OCC_EXTRA_BITS;
  localparam logic [OCC_W-1:0] DEPTH = OCC_W'(SCRATCH_DEPTH);

  logic [1:0]          state;
  logic [ADDR_LEN-1:0] wr_ptr;
  logic [ADDR_LEN-1:0] base;
  logic [ADDR_LEN-1:0] idx;
  logic [OCC_W-1:0]    occ;
  logic                rejected;
  logic [OCC_W-1:0]    win_q;
  logic [OCC_W-1:0]    stride_q;

  logic                fire;
  logic                win_bad;
  logic                is_last;
  logic [ADDR_LEN-1:0] wr_ptr_inc;
  logic [ADDR_LEN-1:0] base_adv;

  function automatic logic [OCC_W-1:0] clamp_stride(input logic [OCC_W-1:0] s,
                                                     input logic [OCC_W-1:0] len);
    return (s > len) ? len : s;
  endfunction

  assign full      = (occ == DEPTH);
  assign empty     = (occ == '0);
  assign wr_ready  = !full;
  assign fire      = wr_en & wr_ready;
  assign wr_addr   = wr_ptr;
  assign occupancy = occ;

  assign win_bad   = (win_len == '0) || (win_len > DEPTH);
  assign is_last   = ({1'b0, idx} == (win_q - OCC_W'(1)));

  assign rd_valid  = (state == ST_READ);
  assign rd_last   = rd_valid & is_last;
  assign done      = (state == ST_ADV);
  assign err       = done & rejected;
  assign busy      = (state != ST_IDLE);

  ring_ptr_add #(.ADDR_LEN(ADDR_LEN), .SCRATCH_DEPTH(SCRATCH_DEPTH)) u_wr_inc (
    .a   (wr_ptr),
    .b   (OCC_W'(1)),
    .sum (wr_ptr_inc)
  );

  ring_ptr_add #(.ADDR_LEN(ADDR_LEN), .SCRATCH_DEPTH(SCRATCH_DEPTH)) u_rd_addr (
    .a   (base),
    .b   ({1'b0, idx}),
    .sum (rd_addr)
  );

  ring_ptr_add #(.ADDR_LEN(ADDR_LEN), .SCRATCH_DEPTH(SCRATCH_DEPTH)) u_base_adv (
    .a   (base),
    .b   (stride_q),
    .sum (base_adv)
  );

  // control state: pointers, occupancy and FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      wr_ptr   <= '0;
      base     <= '0;
      idx      <= '0;
      occ      <= '0;
      rejected <= 1'b0;
    end else begin
      if (fire) wr_ptr <= wr_ptr_inc;
      // push and release in the same cycle net out; release never exceeds occupancy
      occ <= occ + OCC_W'(fire) - ((state == ST_ADV) ? stride_q : '0);
      case (state)
        ST_IDLE: begin
          if (start) begin
            rejected <= win_bad;
            state    <= win_bad ? ST_ADV : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (occ >= win_q) begin
            idx   <= '0;
            state <= ST_READ;
          end
        end
        ST_READ: begin
          if (rd_ready) begin
            if (is_last) state <= ST_ADV;
            else         idx   <= idx + ADDR_LEN'(1);
          end
        end
        ST_ADV: begin
          base  <= base_adv;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // window parameters captured at start; a rejected window releases nothing
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && start) begin
      win_q    <= win_len;
      stride_q <= win_bad ? '0 : clamp_stride(stride, win_len);
    end
  end

endmodule

// File: tb/tb_scratch_ring_window_ctrl.sv
// Bench for scratch_ring_window_ctrl: depth-16 and depth-12 instances driven through a
// shared stimulus set, with a reference model and an expected-address queue.
module tb_scratch_ring_window_ctrl;

  localparam int AL = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        sel = 1'b0;
  logic        wr_en = 1'b0, start = 1'b0, rd_ready = 1'b0;
  logic [AL:0] win_len = '0, stride = '0;

  logic a_wr_ready, a_rd_valid, a_rd_last, a_done, a_err, a_busy, a_full, a_empty;
  logic b_wr_ready, b_rd_valid, b_rd_last, b_done, b_err, b_busy, b_full, b_empty;
  logic [AL-1:0] a_wr_addr, a_rd_addr, b_wr_addr, b_rd_addr;
  logic [AL:0]   a_occ, b_occ;

  logic wr_ready, rd_valid, rd_last, done, err, busy, full, empty;
  logic [AL-1:0] wr_addr, rd_addr;
  logic [AL:0]   occupancy;

  assign {wr_ready, rd_valid, rd_last, done, err, busy, full, empty, wr_addr, rd_addr, occupancy} = sel ?
    {b_wr_ready, b_rd_valid, b_rd_last, b_done, b_err, b_busy, b_full, b_empty, b_wr_addr, b_rd_addr, b_occ} :
    {a_wr_ready, a_rd_valid, a_rd_last, a_done, a_err, a_busy, a_full, a_empty, a_wr_addr, a_rd_addr, a_occ};

  scratch_ring_window_ctrl #(.ADDR_LEN(AL), .SCRATCH_DEPTH(16)) dut16 (
    .clk(clk), .rst(rst), .wr_en(wr_en & ~sel), .wr_ready(a_wr_ready), .wr_addr(a_wr_addr),
    .start(start & ~sel), .win_len(win_len), .stride(stride), .rd_ready(rd_ready & ~sel),
    .rd_valid(a_rd_valid), .rd_addr(a_rd_addr), .rd_last(a_rd_last), .done(a_done), .err(a_err),
    .busy(a_busy), .occupancy(a_occ), .full(a_full), .empty(a_empty)
  );

  scratch_ring_window_ctrl #(.ADDR_LEN(AL), .SCRATCH_DEPTH(12)) dut12 (
    .clk(clk), .rst(rst), .wr_en(wr_en & sel), .wr_ready(b_wr_ready), .wr_addr(b_wr_addr),
    .start(start & sel), .win_len(win_len), .stride(stride), .rd_ready(rd_ready & sel),
    .rd_valid(b_rd_valid), .rd_addr(b_rd_addr), .rd_last(b_rd_last), .done(b_done), .err(b_err),
    .busy(b_busy), .occupancy(b_occ), .full(b_full), .empty(b_empty)
  );

  int n_vec = 0;
  int n_err = 0;
  int m_depth = 16, m_base = 0, m_occ = 0, m_wp = 0, m_rel = 0;
  int q_addr[$];

  // advance one clock, applying the model's push and (optionally) the window release
  task automatic step(input int rel, input bit adv);
    if (wr_en && m_occ < m_depth) begin
      m_occ++;
      m_wp = (m_wp + 1) % m_depth;
    end
    if (adv) begin
      m_occ  -= rel;
      m_base  = (m_base + rel) % m_depth;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int n);
    wr_en = 1'b1;
    for (int i = 0; i < n; i++) begin
      n_vec++;
      if (wr_ready !== (m_occ < m_depth)) begin
        n_err++; $display("FAIL push_wr_ready: got %b want %b", wr_ready, (m_occ < m_depth));
      end
      if (m_occ < m_depth) begin
        n_vec++;
        if (wr_addr !== 4'(m_wp)) begin
          n_err++; $display("FAIL push_wr_addr: got %0d want %0d", wr_addr, m_wp);
        end
      end
      step(0, 1'b0);
    end
    wr_en = 1'b0;
    n_vec++;
    if (occupancy !== 5'(m_occ)) begin
      n_err++; $display("FAIL push_occupancy: got %0d want %0d", occupancy, m_occ);
    end
  endtask

  task automatic start_win(input int wl, input int st);
    m_rel = (st < wl) ? st : wl;
    for (int i = 0; i < wl; i++) q_addr.push_back((m_base + i) % m_depth);
    start = 1'b1; win_len = 5'(wl); stride = 5'(st);
    step(0, 1'b0);
    start = 1'b0; win_len = 5'd3; stride = 5'd0;
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++; $display("FAIL start_busy: got %b want 1", busy);
    end
  endtask

  task automatic consume(input bit toggle, input bit hold_start);
    int  cyc = 0;
    int  phase = 0;
    bit  last_seen = 1'b0;
    bit  exp_last;
    while (!last_seen && cyc < 200) begin
      rd_ready = toggle ? (phase % 2 == 0) : 1'b1;
      if (hold_start) begin start = 1'b1; win_len = 5'd1; end
      if (rd_valid === 1'b1) begin
        if (q_addr.size() == 0) begin
          n_vec++; n_err++; last_seen = 1'b1;
          $display("FAIL extra_rd: got rd_addr %0d want no read", rd_addr);
        end else begin
          n_vec++;
          if (rd_addr !== 4'(q_addr[0])) begin
            n_err++; $display("FAIL rd_addr: got %0d want %0d", rd_addr, q_addr[0]);
          end
          if (rd_ready) begin
            exp_last = (q_addr.size() == 1);
            n_vec++;
            if (rd_last !== exp_last) begin
              n_err++; $display("FAIL rd_last: got %b want %b", rd_last, exp_last);
            end
            void'(q_addr.pop_front());
            last_seen = exp_last;
          end
        end
        phase++;
      end
      step(0, 1'b0);
      cyc++;
    end
    rd_ready = 1'b0;
    n_vec++;
    if (!last_seen) begin
      n_err++; $display("FAIL window_timeout: got %0d reads left want 0", q_addr.size());
    end
    n_vec++;
    if ({done, err, rd_valid} !== 3'b100) begin
      n_err++; $display("FAIL adv_pulse: got done/err/rd_valid %b want 100", {done, err, rd_valid});
    end
    step(m_rel, 1'b1);
    start = 1'b0;
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0 || occupancy !== 5'(m_occ)) begin
      n_err++; $display("FAIL post_window: got busy %b done %b occ %0d want 0 0 %0d", busy, done, occupancy, m_occ);
    end
    if (hold_start) begin
      step(0, 1'b0);
      n_vec++;
      if (busy !== 1'b0) begin
        n_err++; $display("FAIL start_ignored: got busy %b want 0", busy);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({wr_ready, rd_valid, done, err, busy, empty, full} !== 7'b1000010) begin
      n_err++; $display("FAIL reset_flags: got %b want 1000010", {wr_ready, rd_valid, done, err, busy, empty, full});
    end
    n_vec++;
    if (occupancy !== 5'd0 || wr_addr !== 4'd0) begin
      n_err++; $display("FAIL reset_ptrs: got occ %0d wr_addr %0d want 0 0", occupancy, wr_addr);
    end
    rst = 1'b1;
    m_base = 0; m_occ = 0; m_wp = 0;
  endtask

  task automatic test_basic_window();
    push(5);
    start_win(4, 2);
    n_vec++;
    if (rd_valid !== 1'b0) begin
      n_err++; $display("FAIL latency_wait: got rd_valid %b want 0", rd_valid);
    end
    step(0, 1'b0);
    n_vec++;
    if (rd_valid !== 1'b1) begin
      n_err++; $display("FAIL latency_first: got rd_valid %b want 1", rd_valid);
    end
    consume(1'b0, 1'b0);
  endtask

  task automatic test_wait_for_data();
    start_win(6, 6);
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (rd_valid !== 1'b0 || busy !== 1'b1) begin
        n_err++; $display("FAIL wait_hold: got rd_valid %b busy %b want 0 1", rd_valid, busy);
      end
      step(0, 1'b0);
    end
    push(3);
    n_vec++;
    if (rd_valid !== 1'b0) begin
      n_err++; $display("FAIL wait_edge: got rd_valid %b want 0", rd_valid);
    end
    step(0, 1'b0);
    n_vec++;
    if (rd_valid !== 1'b1) begin
      n_err++; $display("FAIL wait_release: got rd_valid %b want 1", rd_valid);
    end
    consume(1'b0, 1'b0);
  endtask

  task automatic test_full();
    push(m_depth);
    n_vec++;
    if (full !== 1'b1 || wr_ready !== 1'b0 || empty !== 1'b0) begin
      n_err++; $display("FAIL full_flags: got full %b wr_ready %b empty %b want 1 0 0", full, wr_ready, empty);
    end
    push(2);
    n_vec++;
    if (wr_addr !== 4'(m_wp)) begin
      n_err++; $display("FAIL full_wr_ptr: got %0d want %0d", wr_addr, m_wp);
    end
    wr_en = 1'b1;
    start_win(4, 4);
    consume(1'b0, 1'b0);
    push(1);
  endtask

  task automatic test_reject();
    int lens[2] = '{0, 17};
    foreach (lens[k]) begin
      int seen = 0;
      int bad  = 0;
      start = 1'b1; win_len = 5'(lens[k]); stride = 5'd2;
      step(0, 1'b0);
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
        if (done === 1'b1) begin
          seen++;
          if (err !== 1'b1) bad++;
        end
        if (rd_valid !== 1'b0) bad++;
        step(0, 1'b0);
      end
      n_vec++;
      if (seen != 1 || bad != 0) begin
        n_err++; $display("FAIL reject_len%0d: got %0d done pulses %0d bad cycles want 1 0", lens[k], seen, bad);
      end
      n_vec++;
      if (busy !== 1'b0 || occupancy !== 5'(m_occ)) begin
        n_err++; $display("FAIL reject_state: got busy %b occ %0d want 0 %0d", busy, occupancy, m_occ);
      end
    end
  endtask

  task automatic test_rd_ready_toggle();
    start_win(3, 1);
    consume(1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    wr_en = 1'b1;
    start_win(4, 0);
    consume(1'b0, 1'b1);
    start_win(4, 4);
    consume(1'b0, 1'b0);
    wr_en = 1'b0;
  endtask

  task automatic test_reset_mid_read();
    start_win(4, 1);
    rd_ready = 1'b0;
    step(0, 1'b0);
    n_vec++;
    if (rd_valid !== 1'b1 || rd_addr !== 4'(q_addr[0])) begin
      n_err++; $display("FAIL mid_first: got valid %b addr %0d want 1 %0d", rd_valid, rd_addr, q_addr[0]);
    end
    rd_ready = 1'b1;
    step(0, 1'b0);
    rd_ready = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    n_vec++;
    if ({wr_ready, rd_valid, done, err, busy, empty, full} !== 7'b1000010 || occupancy !== 5'd0) begin
      n_err++; $display("FAIL mid_reset: got %b occ %0d want 1000010 0", {wr_ready, rd_valid, done, err, busy, empty, full}, occupancy);
    end
    @(posedge clk);
    #1;
    n_vec++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL mid_no_done: got done %b busy %b want 0 0", done, busy);
    end
    rst = 1'b1;
    m_base = 0; m_occ = 0; m_wp = 0;
    q_addr.delete();
  endtask

  task automatic test_depth12_wrap();
    sel = 1'b1;
    m_depth = 12; m_base = 0; m_occ = 0; m_wp = 0;
    #1;
    push(12);
    start_win(10, 10);
    consume(1'b0, 1'b0);
    push(10);
    start_win(4, 4);
    consume(1'b0, 1'b0);
    start_win(1, 0);
    consume(1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic_window();
    test_wait_for_data();
    test_full();
    test_reject();
    test_rd_ready_toggle();
    test_back_to_back();
    test_reset_mid_read();
    test_depth12_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
